// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sharing one cache port between fetch (I) and load/store (D)
module cache_port_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDRESS_WIDTH  = 10,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic                     i_clk,
  input  logic                     i_aresetn,
  input  logic                     i_if_req,
  input  logic [ADDRESS_WIDTH-1:0] i_if_addr,
  output logic                     o_if_ack,
  output logic [BUS_WIDTH-1:0]     o_if_rdata,
  output logic                     o_if_err,
  input  logic                     i_d_req,
  input  logic                     i_d_we,
  input  logic [ADDRESS_WIDTH-1:0] i_d_addr,
  input  logic [BUS_WIDTH-1:0]     i_d_wdata,
  output logic                     o_d_ack,
  output logic [BUS_WIDTH-1:0]     o_d_rdata,
  output logic                     o_d_err,
  output logic                     o_MemRead,
  output logic                     o_MemWrite,
  output logic [ADDRESS_WIDTH-1:0] o_AddressCpu,
  output logic [BUS_WIDTH-1:0]     o_data,
  input  logic [BUS_WIDTH-1:0]     i_DataToCpu,
  input  logic                     i_stall
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_owner;       // 1 = port D
  logic                     r_last_grant;  // 1 = port D
  logic                     r_op;          // 1 = write
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0]     r_wdata;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_if_ack, r_if_err, r_d_ack, r_d_err;
  logic [BUS_WIDTH-1:0]     r_if_rdata, r_d_rdata;

  logic                     w_grant, w_grant_d, w_done, w_timeout, w_busy;
  logic [BUS_WIDTH-1:0]     w_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_if_req || i_d_req) begin
          w_grant     = 1'b1;
          // On a tie, D wins only if I was the last port served
          w_grant_d   = i_d_req && (!i_if_req || !r_last_grant);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!i_stall) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Writes and timeouts return zero read data
  assign w_rdata = (w_done && !r_op) ? i_DataToCpu : '0;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_if_ack     <= 1'b0;
      r_if_err     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_if_err <= 1'b0;
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      if (w_grant) begin
        r_owner      <= w_grant_d;
        r_last_grant <= w_grant_d;
        r_op         <= w_grant_d && i_d_we;
        r_addr       <= w_grant_d ? i_d_addr : i_if_addr;
        r_wdata      <= w_grant_d ? i_d_wdata : '0;
        r_cnt        <= '0;
      end
      if (r_state == S_BUSY && i_stall && !w_timeout)
        r_cnt <= r_cnt + 1'b1;
      if (w_done || w_timeout) begin
        if (r_owner) begin
          r_d_ack   <= 1'b1;
          r_d_err   <= w_timeout;
          r_d_rdata <= w_rdata;
        end else begin
          r_if_ack   <= 1'b1;
          r_if_err   <= w_timeout;
          r_if_rdata <= w_rdata;
        end
      end
    end
  end

  assign w_busy       = (r_state == S_BUSY);
  assign o_MemRead    = w_busy && !r_op;
  assign o_MemWrite   = w_busy && r_op;
  assign o_AddressCpu = w_busy ? r_addr : '0;
  assign o_data       = w_busy ? r_wdata : '0;
  assign o_if_ack     = r_if_ack;
  assign o_if_err     = r_if_err;
  assign o_if_rdata   = r_if_rdata;
  assign o_d_ack      = r_d_ack;
  assign o_d_err      = r_d_err;
  assign o_d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed-vector bench for cache_port_arbiter
module tb_cache_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_aresetn;
  logic        i_if_req;
  logic [9:0]  i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;
  logic        o_if_err;
  logic        i_d_req;
  logic        i_d_we;
  logic [9:0]  i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_ack;
  logic [31:0] o_d_rdata;
  logic        o_d_err;
  logic        o_MemRead;
  logic        o_MemWrite;
  logic [9:0]  o_AddressCpu;
  logic [31:0] o_data;
  logic [31:0] i_DataToCpu;
  logic        i_stall;

  int n_vec  = 0;
  int n_miss = 0;

  cache_port_arbiter #(
    .BUS_WIDTH(32), .ADDRESS_WIDTH(10), .TIMEOUT_CYCLES(64), .CNT_WIDTH(7)
  ) dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack),
    .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_AddressCpu(o_AddressCpu),
    .o_data(o_data), .i_DataToCpu(i_DataToCpu), .i_stall(i_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  initial begin
    i_aresetn   = 1'b0;
    i_if_req    = 1'b0;
    i_if_addr   = '0;
    i_d_req     = 1'b0;
    i_d_we      = 1'b0;
    i_d_addr    = '0;
    i_d_wdata   = '0;
    i_DataToCpu = 32'hDEADBEEF;
    i_stall     = 1'b0;

    step();
    check("rst_memread", 32'(o_MemRead), 32'd0);
    check("rst_if_ack", 32'(o_if_ack), 32'd0);
    check("rst_d_ack", 32'(o_d_ack), 32'd0);
    check("rst_addr", 32'(o_AddressCpu), 32'd0);
    step();
    i_aresetn = 1'b1;

    // single I read hit
    i_if_req  = 1'b1;
    i_if_addr = 10'h010;
    step();
    check("t1_memread", 32'(o_MemRead), 32'd1);
    check("t1_memwrite", 32'(o_MemWrite), 32'd0);
    check("t1_addr", 32'(o_AddressCpu), 32'h010);
    check("t1_d_ack_busy", 32'(o_d_ack), 32'd0);
    step();
    check("t1_if_ack", 32'(o_if_ack), 32'd1);
    check("t1_if_rdata", o_if_rdata, 32'hDEADBEEF);
    check("t1_if_err", 32'(o_if_err), 32'd0);
    check("t1_d_ack_resp", 32'(o_d_ack), 32'd0);
    check("t1_resp_memread", 32'(o_MemRead), 32'd0);
    i_if_req = 1'b0;
    step();
    check("t1_if_ack_clr", 32'(o_if_ack), 32'd0);

    // D write with 5 stall cycles
    i_d_req   = 1'b1;
    i_d_we    = 1'b1;
    i_d_addr  = 10'h3FF;
    i_d_wdata = 32'h12345678;
    i_stall   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_memwrite", 32'(o_MemWrite), 32'd1);
      check("t2_memread", 32'(o_MemRead), 32'd0);
      check("t2_addr", 32'(o_AddressCpu), 32'h3FF);
      check("t2_data", o_data, 32'h12345678);
      check("t2_d_ack_busy", 32'(o_d_ack), 32'd0);
      if (i == 5) i_stall = 1'b0;
    end
    step();
    check("t2_d_ack", 32'(o_d_ack), 32'd1);
    check("t2_d_err", 32'(o_d_err), 32'd0);
    check("t2_d_rdata", o_d_rdata, 32'd0);
    check("t2_resp_memwrite", 32'(o_MemWrite), 32'd0);
    i_d_req = 1'b0;
    i_d_we  = 1'b0;
    step();
    check("t2_d_ack_clr", 32'(o_d_ack), 32'd0);

    // both requests held from reset: I, D, I, D
    i_aresetn = 1'b0;
    step();
    i_aresetn   = 1'b1;
    i_if_req    = 1'b1;
    i_if_addr   = 10'h055;
    i_d_req     = 1'b1;
    i_d_addr    = 10'h2AA;
    i_DataToCpu = 32'hA5A50F0F;
    for (int c = 1; c <= 12; c++) begin
      int  ph;
      logic pd;
      step();
      ph = c % 3;
      pd = (((c - 1) / 3) % 2) == 1;
      check("rr_if_ack", 32'(o_if_ack), 32'(ph == 2 && !pd));
      check("rr_d_ack", 32'(o_d_ack), 32'(ph == 2 && pd));
      check("rr_memread", 32'(o_MemRead), 32'(ph == 1));
      if (ph == 1) check("rr_addr", 32'(o_AddressCpu), pd ? 32'h2AA : 32'h055);
      if (ph == 2 && pd) check("rr_d_rdata", o_d_rdata, 32'hA5A50F0F);
      if (c == 12) begin
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
      end
    end

    // D read timeout, then I hit completes normally
    step();
    i_d_req  = 1'b1;
    i_d_addr = 10'h077;
    i_stall  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      check("to_memread", 32'(o_MemRead), 32'd1);
      check("to_d_ack_busy", 32'(o_d_ack), 32'd0);
    end
    step();
    check("to_d_ack", 32'(o_d_ack), 32'd1);
    check("to_d_err", 32'(o_d_err), 32'd1);
    check("to_d_rdata", o_d_rdata, 32'd0);
    check("to_resp_memread", 32'(o_MemRead), 32'd0);
    i_d_req     = 1'b0;
    i_stall     = 1'b0;
    i_if_req    = 1'b1;
    i_if_addr   = 10'h123;
    i_DataToCpu = 32'hCAFEF00D;
    step();
    check("to_idle_d_ack", 32'(o_d_ack), 32'd0);
    check("to_idle_d_err", 32'(o_d_err), 32'd0);
    step();
    check("to_i_addr", 32'(o_AddressCpu), 32'h123);
    step();
    check("to_i_ack", 32'(o_if_ack), 32'd1);
    check("to_i_err", 32'(o_if_err), 32'd0);
    check("to_i_rdata", o_if_rdata, 32'hCAFEF00D);
    i_if_req = 1'b0;
    step();

    // asynchronous reset mid-BUSY
    i_d_req  = 1'b1;
    i_d_addr = 10'h0AB;
    i_stall  = 1'b1;
    step();
    check("ar_busy_memread", 32'(o_MemRead), 32'd1);
    #2 i_aresetn = 1'b0;
    #1;
    check("ar_memread", 32'(o_MemRead), 32'd0);
    check("ar_addr", 32'(o_AddressCpu), 32'd0);
    check("ar_if_rdata", o_if_rdata, 32'd0);
    check("ar_d_ack", 32'(o_d_ack), 32'd0);
    i_d_req = 1'b0;
    i_stall = 1'b0;
    step();
    i_aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_no_ack", 32'(o_d_ack), 32'd0);
      check("ar_idle_memread", 32'(o_MemRead), 32'd0);
    end
    i_d_req     = 1'b1;
    i_DataToCpu = 32'h0BADCAFE;
    step();
    check("ar_re_addr", 32'(o_AddressCpu), 32'h0AB);
    step();
    check("ar_re_ack", 32'(o_d_ack), 32'd1);
    check("ar_re_rdata", o_d_rdata, 32'h0BADCAFE);
    i_d_req = 1'b0;
    step();

    // I drops req in BUSY; D request waits until after RESP
    i_if_req  = 1'b1;
    i_if_addr = 10'h0F0;
    i_stall   = 1'b1;
    step();
    check("dr_busy_addr", 32'(o_AddressCpu), 32'h0F0);
    i_if_req  = 1'b0;
    i_d_req   = 1'b1;
    i_d_we    = 1'b1;
    i_d_addr  = 10'h100;
    i_d_wdata = 32'h00000055;
    step();
    check("dr_still_i", 32'(o_AddressCpu), 32'h0F0);
    check("dr_still_read", 32'(o_MemWrite), 32'd0);
    i_stall = 1'b0;
    step();
    check("dr_if_ack", 32'(o_if_ack), 32'd1);
    check("dr_resp_memwrite", 32'(o_MemWrite), 32'd0);
    step();
    check("dr_if_ack_once", 32'(o_if_ack), 32'd0);
    check("dr_idle_memwrite", 32'(o_MemWrite), 32'd0);
    step();
    check("dr_d_memwrite", 32'(o_MemWrite), 32'd1);
    check("dr_d_addr", 32'(o_AddressCpu), 32'h100);
    check("dr_d_data", o_data, 32'h00000055);
    step();
    check("dr_d_ack", 32'(o_d_ack), 32'd1);
    check("dr_if_ack_quiet", 32'(o_if_ack), 32'd0);
    i_d_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
